nx_credit_tx: RTL and testbench

NX_CREDIT_TX -- requirements
Module: nx_credit_tx

---
 rtl/nx_credit_tx.sv | 171 +++++++++++++++++
 tb/tb_nx_credit_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_credit_tx.sv
`default_nettype none
// ============================================================================
// Module      : nx_credit_tx
// Description : Credit-based transmitter feeding a remote receive FIFO of
//               DEPTH entries. One credit is spent per word written and one
//               is recovered per credit_ret pulse. A flush drains all
//               outstanding credits before reporting quiescence.
//
// Ports       : clk             - sole clock, rising edge
//               rst             - synchronous active-high reset
//               enable          - level, allows leaving IDLE
//               in_valid        - upstream word offered
//               in_data         - upstream payload [DATA_W]
//               in_ready        - upstream word accepted (registered decode)
//               out_valid       - write strobe to the remote FIFO
//               out_data        - payload to the remote FIFO [DATA_W]
//               credit_ret      - pulse, remote FIFO popped one entry
//               flush_req       - pulse, request drain to quiescence
//               flush_done      - pulse, drain complete
//               credits         - current credit count [CW], registered
//               credit_overflow - pulse, credit returned while already full
//
// Revision    : 1.0 - initial release
// ============================================================================
module nx_credit_tx #(
    parameter int DEPTH  = 6,
    parameter int DATA_W = 32,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              credit_ret,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [CW-1:0]     credits,
    output logic              credit_overflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;

    localparam logic [CW-1:0] c_DEPTH     = CW'(DEPTH);
    localparam logic [CW:0]   c_DEPTH_EXT = (CW + 1)'(DEPTH);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [CW-1:0]     r_credits;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_flush_done;
    logic              r_credit_overflow;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]    w_state_nxt;
    logic          w_flush_done_nxt;
    logic          w_in_ready;
    logic          w_send;
    logic          w_ret_acc;
    logic          w_ret_ovf;
    logic [CW:0]   w_credits_sum;
    logic [CW-1:0] w_credits_nxt;

    // in_ready depends only on registered state so upstream sees no
    // combinational path from any input.
    assign w_in_ready = (r_state == c_ST_ACTIVE) && (r_credits != '0);
    assign w_send     = in_valid & w_in_ready;

    // A return while already holding every credit cannot be legal; it is
    // dropped and flagged instead of pushing the count past DEPTH.
    assign w_ret_acc  = credit_ret & (r_credits != c_DEPTH);
    assign w_ret_ovf  = credit_ret & (r_credits == c_DEPTH);

    // One spare bit so the add/subtract cannot wrap. A send needs a nonzero
    // count and an accepted return needs a count below DEPTH, so the sum
    // always lands in 0..DEPTH; the clamp only guards that invariant.
    assign w_credits_sum = {1'b0, r_credits}
                         - {{CW{1'b0}}, w_send}
                         + {{CW{1'b0}}, w_ret_acc};
    assign w_credits_nxt = (w_credits_sum > c_DEPTH_EXT) ? c_DEPTH
                                                         : w_credits_sum[CW-1:0];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // Nothing outstanding to drain: a flush completes at once
                // and takes priority over enable.
                if (flush_req) begin
                    w_flush_done_nxt = 1'b1;
                end else if (enable) begin
                    w_state_nxt = c_ST_ACTIVE;
                end
            end
            c_ST_ACTIVE: begin
                if (flush_req) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                // Leave on the edge that makes the registered count reach
                // DEPTH with no write in flight, so flush_done, the IDLE
                // state and the full credit count all appear together.
                if ((w_credits_nxt == c_DEPTH) && !w_send) begin
                    w_state_nxt      = c_ST_IDLE;
                    w_flush_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= c_ST_IDLE;
            r_credits         <= c_DEPTH;
            r_out_valid       <= 1'b0;
            r_out_data        <= '0;
            r_flush_done      <= 1'b0;
            r_credit_overflow <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_credits         <= w_credits_nxt;
            r_out_valid       <= w_send;
            r_flush_done      <= w_flush_done_nxt;
            r_credit_overflow <= w_ret_ovf;
            if (w_send) begin
                r_out_data <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready        = w_in_ready;
    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign flush_done      = r_flush_done;
    assign credits         = r_credits;
    assign credit_overflow = r_credit_overflow;

    // The credit count can never exceed the remote FIFO depth.
    a_credits_bounded : assert property (
        @(posedge clk) disable iff (rst) (r_credits <= c_DEPTH)
    );

endmodule
`default_nettype wire

// File: tb/tb_nx_credit_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_nx_credit_tx
// Description : Self-checking bench for nx_credit_tx. A behavioural model
//               tracks the credit pool and flow state with plain integers and
//               is compared against the DUT on every cycle; directed phases
//               pin the model with hand-computed literal expectations, then a
//               randomized phase exercises all inputs together.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nx_credit_tx;

    localparam int DEPTH  = 6;
    localparam int DATA_W = 32;
    localparam int CW     = $clog2(DEPTH + 1);

    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_DRAIN  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              credit_ret;
    logic              flush_req;
    logic              flush_done;
    logic [CW-1:0]     credits;
    logic              credit_overflow;

    int total = 0;
    int bad   = 0;

    nx_credit_tx #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .credit_ret      (credit_ret),
        .flush_req       (flush_req),
        .flush_done      (flush_done),
        .credits         (credits),
        .credit_overflow (credit_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: a credit pool counted as an integer, a word-in-flight
    // flag and the last written payload.
    // ------------------------------------------------------------------------
    int                m_st   = M_IDLE;
    int                m_cr   = DEPTH;
    bit                m_ov   = 1'b0;
    logic [DATA_W-1:0] m_od   = '0;
    bit                m_fd   = 1'b0;
    bit                m_cov  = 1'b0;
    bit                chk_en = 1'b0;
    bit                m_rdy;
    bit                m_snd;

    always @(posedge clk) begin
        if (rst) begin
            m_st   = M_IDLE;
            m_cr   = DEPTH;
            m_ov   = 1'b0;
            m_od   = '0;
            m_fd   = 1'b0;
            m_cov  = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_rdy = (m_st == M_ACTIVE) && (m_cr > 0);
            m_snd = in_valid && m_rdy;
            m_cov = credit_ret && (m_cr == DEPTH);
            if (m_snd) m_cr = m_cr - 1;
            if (credit_ret && !m_cov) m_cr = m_cr + 1;
            m_ov = m_snd;
            if (m_snd) m_od = in_data;
            m_fd = 1'b0;
            if (m_st == M_IDLE) begin
                if (flush_req) m_fd = 1'b1;
                else if (enable) m_st = M_ACTIVE;
            end else if (m_st == M_ACTIVE) begin
                if (flush_req) m_st = M_DRAIN;
            end else begin
                if (m_cr == DEPTH) begin
                    m_st = M_IDLE;
                    m_fd = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",        in_ready,        ((m_st == M_ACTIVE) && (m_cr > 0)));
            chk("out_valid",       out_valid,       m_ov);
            chk("out_data",        out_data,        m_od);
            chk("credits",         credits,         m_cr);
            chk("flush_done",      flush_done,      m_fd);
            chk("credit_overflow", credit_overflow, m_cov);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus with literal expectations
    // ------------------------------------------------------------------------
    int nv, first_i, last_i, ok, fdn, rdy_hi, cr_at;

    initial begin
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
        credit_ret = 1'b0; flush_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_credits",   credits,   6);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);

        // Six back-to-back sends from a full pool, then stall.
        rst = 1'b0; enable = 1'b1; in_valid = 1'b1; in_data = $urandom;
        @(negedge clk);
        chk("first_cycle_credits", credits, 6);
        nv = 0; first_i = -1; last_i = -1;
        for (int i = 0; i < 12; i++) begin
            in_data = $urandom;
            @(negedge clk);
            if (out_valid) begin
                nv++;
                if (first_i < 0) first_i = i;
                last_i = i;
            end
        end
        chk("burst_sends",       nv, 6);
        chk("burst_consecutive", last_i - first_i, 5);
        chk("burst_credits",     credits, 0);
        chk("burst_in_ready",    in_ready, 0);

        // Single credit back from empty: one more send.
        credit_ret = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        chk("ret1_credits",  credits, 1);
        chk("ret1_in_ready", in_ready, 1);
        @(negedge clk);
        chk("ret1_send_credits",  credits, 0);
        chk("ret1_send_valid",    out_valid, 1);
        chk("ret1_send_in_ready", in_ready, 0);
        @(negedge clk);
        chk("ret1_after_valid", out_valid, 0);

        // Build up to 3 credits, then send and return together for 10 cycles.
        in_valid = 1'b0; credit_ret = 1'b1;
        repeat (3) @(negedge clk);
        chk("three_credits", credits, 3);
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            in_data = $urandom;
            @(negedge clk);
            if ((credits == 3) && out_valid) ok++;
        end
        chk("steady_cycles", ok, 10);

        // Drop to 2 credits, flush, then four returns spaced 3 cycles apart.
        credit_ret = 1'b0; in_data = $urandom;
        @(negedge clk);
        in_valid = 1'b0; enable = 1'b0;
        chk("two_credits", credits, 2);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        fdn = 0; rdy_hi = in_ready; cr_at = -1;
        for (int k = 0; k < 4; k++) begin
            credit_ret = 1'b1;
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                credit_ret = 1'b0;
                rdy_hi += in_ready;
                if (flush_done) begin
                    fdn++;
                    cr_at = credits;
                end
            end
        end
        chk("drain_flush_done_count", fdn, 1);
        chk("drain_credits_at_done",  cr_at, 6);
        chk("drain_in_ready_high",    rdy_hi, 0);

        // Full pool in IDLE: an extra return overflows and is discarded.
        credit_ret = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        chk("ovf_pulse",   credit_overflow, 1);
        chk("ovf_credits", credits, 6);
        @(negedge clk);
        chk("ovf_pulse_end", credit_overflow, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("idle_to_active", in_ready, 1);

        // Reach DRAIN holding 4 credits, then reset in the middle of it.
        in_valid = 1'b1;
        repeat (2) begin
            in_data = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0; enable = 1'b0; flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        @(negedge clk);
        chk("drain4_credits", credits, 4);
        rst = 1'b1; credit_ret = 1'b1;
        @(negedge clk);
        rst = 1'b0; credit_ret = 1'b0;
        chk("midrst_credits",    credits, 6);
        chk("midrst_out_valid",  out_valid, 0);
        chk("midrst_flush_done", flush_done, 0);
        chk("midrst_in_ready",   in_ready, 0);
        @(negedge clk);
        chk("midrst_after_flush_done", flush_done, 0);
        chk("midrst_after_in_ready",   in_ready, 0);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            enable     = ($urandom_range(0, 3) != 0);
            in_valid   = ($urandom_range(0, 2) != 0);
            in_data    = $urandom;
            credit_ret = ($urandom_range(0, 2) == 0);
            flush_req  = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end

        rst = 1'b0; enable = 1'b0; in_valid = 1'b0;
        credit_ret = 1'b0; flush_req = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
